// File: rtl/f1_start_sequencer.sv
// f1_start_sequencer: F1 start lights with programmable tick, random hold and reaction timer
module f1_start_sequencer #(
    parameter int WIDTH  = 16,
    parameter int LFSR_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] N,
    input  logic             trigger,
    input  logic             react,
    output logic [7:0]       data_out,
    output logic [15:0]      react_time,
    output logic             valid,
    output logic             false_start,
    output logic             busy
);
    typedef enum logic [2:0] {IDLE, LIGHTS, HOLD, GO, DONE} state_t;

    // Maximal-length Fibonacci tap masks, bit k-1 set for polynomial term x^k
    function automatic logic [31:0] tap_mask(input int w);
        case (w)
            2:       return 32'h0003;
            3:       return 32'h0006;
            4:       return 32'h000C;
            5:       return 32'h0014;
            6:       return 32'h0030;
            7:       return 32'h0060;
            8:       return 32'h00B8;
            9:       return 32'h0110;
            10:      return 32'h0240;
            11:      return 32'h0500;
            12:      return 32'h0E08;
            13:      return 32'h1C80;
            14:      return 32'h3802;
            15:      return 32'h6000;
            16:      return 32'hD008;
            default: return 32'h3 << (w - 2);
        endcase
    endfunction

    localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(tap_mask(LFSR_W));
    localparam logic [LFSR_W-1:0] HOLD_LAST = LFSR_W'(1);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  cnt_q, cnt_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d, hold_q, hold_d;
    logic [7:0]        lamps_q, lamps_d;
    logic [15:0]       rt_q, rt_d;
    logic              valid_q, valid_d, fs_q, fs_d, busy_q, busy_d;
    logic              active, tick;

    assign active = state_q == LIGHTS || state_q == HOLD;
    assign tick   = active && cnt_q == '0;
    assign cnt_d  = (!active || tick) ? N : cnt_q - WIDTH'(1);
    // The zero guard keeps the LFSR alive even if it were ever upset into the lock-up state
    assign lfsr_d = lfsr_q == '0 ? LFSR_W'(1) : {lfsr_q[LFSR_W-2:0], ^(lfsr_q & TAPS)};

    always_comb begin
        state_d = state_q;
        lamps_d = lamps_q;
        hold_d  = hold_q;
        rt_d    = rt_q;
        valid_d = valid_q;
        fs_d    = fs_q;
        if (active && react) begin
            state_d = DONE;
            lamps_d = '0;
            fs_d    = 1'b1;
        end else begin
            case (state_q)
                IDLE: state_d = trigger ? LIGHTS : IDLE;
                LIGHTS: if (tick) begin
                    lamps_d = {lamps_q[6:0], 1'b1};
                    if (lamps_q == 8'h7F) begin
                        hold_d  = lfsr_q;
                        state_d = HOLD;
                    end
                end
                HOLD: if (tick) begin
                    hold_d = hold_q - HOLD_LAST;
                    if (hold_q == HOLD_LAST) begin
                        lamps_d = '0;
                        rt_d    = '0;
                        state_d = GO;
                    end
                end
                GO: if (react) begin
                    valid_d = 1'b1;
                    state_d = DONE;
                end else begin
                    rt_d = rt_q == 16'hFFFF ? rt_q : rt_q + 16'd1;
                end
                DONE: if (trigger) begin
                    state_d = LIGHTS;
                    lamps_d = '0;
                    rt_d    = '0;
                    valid_d = 1'b0;
                    fs_d    = 1'b0;
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = state_d inside {LIGHTS, HOLD, GO};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= N;
            lfsr_q  <= LFSR_W'(1);
            hold_q  <= '0;
            lamps_q <= '0;
            rt_q    <= '0;
            valid_q <= 1'b0;
            fs_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            hold_q  <= hold_d;
            lamps_q <= lamps_d;
            rt_q    <= rt_d;
            valid_q <= valid_d;
            fs_q    <= fs_d;
            busy_q  <= busy_d;
        end
    end

    assign data_out    = lamps_q;
    assign react_time  = rt_q;
    assign valid       = valid_q;
    assign false_start = fs_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_f1_start_sequencer.sv
// tb_f1_start_sequencer: scoreboard bench predicting lamp and result events from the start-light timing rules
module tb_f1_start_sequencer;
    logic        clk = 1'b0, rst = 1'b1, trigger = 1'b0, react = 1'b0;
    logic [15:0] n_in = '0;
    logic [7:0]  data_out;
    logic [15:0] react_time;
    logic        valid, false_start, busy;

    int cyc = 0, errors = 0, checks = 0, rst_edge = 0;
    bit mon_en = 1'b0;
    logic [7:0] pd = '0;
    logic pv = 1'b0, pfs = 1'b0;

    typedef struct {int cyc; logic [7:0] val;} lamp_ev_t;
    typedef struct {int cyc; logic [15:0] rt; logic v; logic fs;} res_ev_t;
    lamp_ev_t lamp_q[$];
    res_ev_t  res_q[$];

    f1_start_sequencer dut (
        .clk(clk), .rst(rst), .N(n_in), .trigger(trigger), .react(react),
        .data_out(data_out), .react_time(react_time), .valid(valid),
        .false_start(false_start), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference LFSR: x^7+x^6+1, seeded with 1 by reset, one shift per cycle
    function automatic logic [6:0] lfsr_at(input int c);
        logic [6:0] v;
        v = 7'd1;
        for (int i = 0; i < c - rst_edge; i++) v = {v[5:0], v[6] ^ v[5]};
        return v;
    endfunction

    task automatic sb_lamp();
        checks++;
        if (lamp_q.size() == 0) begin
            errors++;
            $display("FAIL lamp_event: unexpected data_out=%h at cycle %0d", data_out, cyc);
        end else begin
            if (lamp_q[0].cyc != cyc || lamp_q[0].val !== data_out) begin
                errors++;
                $display("FAIL lamp_event: data_out=%h at cycle %0d, expected %h at cycle %0d",
                         data_out, cyc, lamp_q[0].val, lamp_q[0].cyc);
            end
            void'(lamp_q.pop_front());
        end
    endtask

    task automatic sb_res();
        checks++;
        if (res_q.size() == 0) begin
            errors++;
            $display("FAIL result_event: unexpected valid=%b false_start=%b at cycle %0d", valid, false_start, cyc);
        end else begin
            if (res_q[0].cyc != cyc || res_q[0].rt !== react_time || res_q[0].v !== valid || res_q[0].fs !== false_start) begin
                errors++;
                $display("FAIL result_event: rt=%0d valid=%b fs=%b at cycle %0d, expected rt=%0d valid=%b fs=%b at cycle %0d",
                         react_time, valid, false_start, cyc, res_q[0].rt, res_q[0].v, res_q[0].fs, res_q[0].cyc);
            end
            void'(res_q.pop_front());
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && data_out !== pd) sb_lamp();
        if (mon_en && ((valid && !pv) || (false_start && !pfs))) sb_res();
        pd  <= data_out;
        pv  <= valid;
        pfs <= false_start;
    end

    // mode 0: react in GO cycle param; mode 1: false start param cycles into the run; mode 2: react on the final HOLD tick
    task automatic run_seq(input int n, input int mode, input int param);
        int t, g, rc, lit, lamp_c;
        logic [6:0] l;
        n_in = 16'(n);
        trigger = 1'b1;
        t = cyc;
        l = lfsr_at(t + 8 * (n + 1));
        g = t + 1 + (8 + int'(l)) * (n + 1);
        rc = mode == 0 ? g + param : mode == 1 ? t + 1 + (param % (g - t - 1)) : g - 1;
        lit = 0;
        for (int i = 1; i <= 8; i++) begin
            lamp_c = t + 1 + i * (n + 1);
            if (mode == 0 || lamp_c <= rc) begin
                lamp_q.push_back('{lamp_c, 8'((1 << i) - 1)});
                lit++;
            end
        end
        if (mode == 0) begin
            lamp_q.push_back('{g, 8'h00});
            res_q.push_back('{rc + 1, param > 65535 ? 16'hFFFF : 16'(param), 1'b1, 1'b0});
        end else begin
            if (lit > 0) lamp_q.push_back('{rc + 1, 8'h00});
            res_q.push_back('{rc + 1, 16'h0000, 1'b0, 1'b1});
        end
        step();
        trigger = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_valid", 32'(valid), 32'd0);
        chk("start_false_start", 32'(false_start), 32'd0);
        chk("start_react_time", 32'(react_time), 32'd0);
        while (cyc < rc) step();
        react = 1'b1;
        step();
        react = 1'b0;
        chk("done_busy", 32'(busy), 32'd0);
    endtask

    task automatic run_reset(input int n);
        int t, c5;
        n_in = 16'(n);
        trigger = 1'b1;
        t = cyc;
        c5 = t + 1 + 5 * (n + 1);
        for (int i = 1; i <= 5; i++) lamp_q.push_back('{t + 1 + i * (n + 1), 8'((1 << i) - 1)});
        lamp_q.push_back('{c5 + 1, 8'h00});
        step();
        trigger = 1'b0;
        while (cyc < c5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        rst_edge = cyc;
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_react_time", 32'(react_time), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_false_start", 32'(false_start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_lfsr", 32'(dut.lfsr_q), 32'(lfsr_at(cyc)));
    endtask

    initial begin
        repeat (3) step();
        rst = 1'b0;
        rst_edge = cyc;
        mon_en = 1'b1;
        chk("reset_data_out", 32'(data_out), 32'd0);
        chk("reset_react_time", 32'(react_time), 32'd0);
        chk("reset_valid", 32'(valid), 32'd0);
        chk("reset_false_start", 32'(false_start), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle_data_out", 32'(data_out), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_valid", 32'(valid), 32'd0);
            chk("idle_lfsr", 32'(dut.lfsr_q), 32'(lfsr_at(cyc)));
        end
        run_seq(3, 0, 10);
        for (int i = 0; i < 6; i++) begin
            react = 1'(i % 2);
            step();
            chk("done_hold_rt", 32'(react_time), 32'd10);
            chk("done_hold_valid", 32'(valid), 32'd1);
            chk("done_hold_fs", 32'(false_start), 32'd0);
        end
        react = 1'b0;
        run_seq(1, 1, 6);
        run_seq(2, 2, 0);
        run_seq(0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 3)) step();
            run_seq(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), int'($urandom_range(0, 40)));
        end
        run_seq(0, 0, 70010);
        run_reset(2);
        repeat (4) step();
        run_seq(1, 0, 5);
        repeat (4) step();
        chk("lamp_queue_drained", 32'(lamp_q.size()), 32'd0);
        chk("result_queue_drained", 32'(res_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
